// File: rtl/register_dump_pkg.sv
// Shared constants and FSM encoding for the register-dump sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package register_dump_pkg;

    // Register file geometry, shared with the register file itself.
    localparam int REG_COUNT = 4;
    localparam int REG_W     = 16;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Shadow-captures one register word and offers it as two bytes, high byte first.
// Latency: first byte valid the cycle after load_vld; one byte per accepted handshake.
// Backpressure: byte_dat/byte_vld hold while byte_rdy is low; no byte is dropped or repeated.
module word_byte_serializer
    import register_dump_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_vld,
    input  logic [REG_W-1:0] word_dat,
    input  logic             byte_rdy,
    output logic [7:0]       byte_dat,
    output logic             byte_vld,
    output logic             hi_acc,
    output logic             lo_acc
);

    logic [REG_W-1:0] shadow_q, shadow_d;
    logic             sel_lo_q, sel_lo_d;
    logic             vld_q, vld_d;

    // Next-state: capture a new word, advance HI->LO on handshake, retire after LO.
    always_comb begin
        shadow_d = shadow_q;
        sel_lo_d = sel_lo_q;
        vld_d    = vld_q;
        hi_acc   = vld_q && !sel_lo_q && byte_rdy;
        lo_acc   = vld_q &&  sel_lo_q && byte_rdy;
        if (load_vld) begin
            shadow_d = word_dat;
            sel_lo_d = 1'b0;
            vld_d    = 1'b1;
        end else if (hi_acc) begin
            sel_lo_d = 1'b1;
        end else if (lo_acc) begin
            sel_lo_d = 1'b0;
            vld_d    = 1'b0;
        end
    end

    // Shadow, byte select and valid flops; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            sel_lo_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            sel_lo_q <= sel_lo_d;
            vld_q    <= vld_d;
        end
    end

    // Byte mux decoded purely from flops; idle output is forced to zero.
    always_comb begin
        byte_vld = vld_q;
        if (!vld_q) begin
            byte_dat = 8'h00;
        end else if (sel_lo_q) begin
            byte_dat = shadow_q[7:0];
        end else begin
            byte_dat = shadow_q[REG_W-1 -: 8];
        end
    end

endmodule

// File: rtl/register_dump.sv
// Walks register indices 0..NUM_REGS-1 through a spare read port and streams each word as two bytes.
// Latency: first byte two cycles after Start; 3 cycles per register, Done one cycle after the last byte.
// Backpressure: ByteReady low holds the current byte and stretches the dump cycle-for-cycle.
module register_dump
    import register_dump_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = REG_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic [7:0]        ByteOut,
    output logic              ByteValid,
    input  logic              ByteReady
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              load_vld;
    logic              hi_acc;
    logic              lo_acc;

    // Next-state and index control; Start outside IDLE is simply ignored.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (Start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_vld = 1'b1;
                state_d  = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (hi_acc) begin
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (lo_acc) begin
                    if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                // Return the read port to index 0 so IDLE always presents 0.
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and index registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        Busy   = (state_q != ST_IDLE);
        Done   = (state_q == ST_DONE);
        RdAddr = idx_q;
    end

    word_byte_serializer u_ser (
        .clk      (Clock),
        .rst      (Reset),
        .load_vld (load_vld),
        .word_dat (RdData),
        .byte_rdy (ByteReady),
        .byte_dat (ByteOut),
        .byte_vld (ByteValid),
        .hi_acc   (hi_acc),
        .lo_acc   (lo_acc)
    );

endmodule

// File: tb/tb_register_dump.sv
module tb_register_dump;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Busy;
    logic        Done;
    logic [1:0]  RdAddr;
    logic [15:0] RdData;
    logic [7:0]  ByteOut;
    logic        ByteValid;
    logic        ByteReady;

    logic [15:0] regs [4];
    logic [7:0]  sb_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    // Register file model: combinational third read port.
    assign RdData = regs[RdAddr];

    register_dump dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .ByteOut   (ByteOut),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady)
    );

    // One dump scenario: preload words, ready pattern indexed by cycle%4,
    // optional Start re-pulses, optional mid-dump writes, expected Done cycle.
    typedef struct {
        logic [3:0][15:0] pre;
        logic [3:0]       rdy_pat;
        bit               repulse;
        bit               snap;
        int               exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [3:0] pat, input bit rep, input bit snap,
                                input int done_cyc);
        vec_t v;
        v.pre[0]   = w0;
        v.pre[1]   = w1;
        v.pre[2]   = w2;
        v.pre[3]   = w3;
        v.rdy_pat  = pat;
        v.repulse  = rep;
        v.snap     = snap;
        v.exp_done = done_cyc;
        return v;
    endfunction

    // Cycle t is the interval after edge k+t-1, where edge k samples Start.
    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] w;
        for (int i = 0; i < 4; i++) regs[i] = v.pre[i];
        sb_q.delete();
        for (int i = 0; i < 4; i++) begin
            w = (v.snap && i == 3) ? 16'hBEEF : v.pre[i];
            sb_q.push_back(w[15:8]);
            sb_q.push_back(w[7:0]);
        end
        @(negedge Clock);
        Start     = 1'b1;
        ByteReady = 1'b1;
        @(posedge Clock);
        for (int t = 1; t <= v.exp_done + 3; t++) begin
            @(negedge Clock);
            Start     = v.repulse && (t == 4 || t == 13);
            ByteReady = v.rdy_pat[t % 4];
            if (v.snap && t == 3) begin
                regs[3] = 16'hBEEF;
                regs[0] = 16'h5555;
            end
            check({tag, "_busy"}, 32'(Busy), 32'(t <= v.exp_done));
            check({tag, "_done"}, 32'(Done), 32'(t == v.exp_done));
            if (ByteValid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_extra_byte: got %0h expected no byte", tag, ByteOut);
                end else begin
                    check({tag, "_byte"}, 32'(ByteOut), 32'(sb_q[0]));
                    if (ByteReady) void'(sb_q.pop_front());
                end
            end
        end
        Start = 1'b0;
        check({tag, "_bytes_left"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_rdaddr_idle"}, 32'(RdAddr), 32'd0);
    endtask

    initial begin
        vecs[0] = mk(16'h1234, 16'hABCD, 16'h00FF, 16'h8001, 4'b1111, 1'b0, 1'b0, 13);
        vecs[1] = mk(16'h1234, 16'hABCD, 16'h00FF, 16'h8001, 4'b1001, 1'b0, 1'b0, 17);
        vecs[2] = mk(16'hDEAD, 16'h0000, 16'hFFFF, 16'h5A5A, 4'b0011, 1'b0, 1'b0, 18);
        vecs[3] = mk(16'h0102, 16'h0304, 16'h0506, 16'h0708, 4'b1010, 1'b0, 1'b0, 18);
        vecs[4] = mk(16'h1234, 16'hABCD, 16'h00FF, 16'h8001, 4'b1111, 1'b1, 1'b0, 13);
        vecs[5] = mk(16'h1234, 16'hABCD, 16'h00FF, 16'h8001, 4'b1111, 1'b0, 1'b1, 13);

        Reset     = 1'b1;
        Start     = 1'b0;
        ByteReady = 1'b0;
        for (int i = 0; i < 4; i++) regs[i] = 16'h0000;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_busy",    32'(Busy),      32'd0);
        check("rst_done",    32'(Done),      32'd0);
        check("rst_rdaddr",  32'(RdAddr),    32'd0);
        check("rst_byteout", 32'(ByteOut),   32'd0);
        check("rst_bvalid",  32'(ByteValid), 32'd0);
        Reset = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run_vec(vecs[r], $sformatf("vec%0d", r));
        end

        // Reset in cycle k+6 (SEND_LO of register 1) aborts the dump.
        for (int i = 0; i < 4; i++) regs[i] = vecs[0].pre[i];
        @(negedge Clock);
        Start     = 1'b1;
        ByteReady = 1'b1;
        @(posedge Clock);
        for (int t = 1; t <= 6; t++) begin
            @(negedge Clock);
            Start = 1'b0;
        end
        check("abort_pre_byte", 32'(ByteOut), 32'h00CD);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        check("abort_busy",    32'(Busy),      32'd0);
        check("abort_done",    32'(Done),      32'd0);
        check("abort_rdaddr",  32'(RdAddr),    32'd0);
        check("abort_byteout", 32'(ByteOut),   32'd0);
        check("abort_bvalid",  32'(ByteValid), 32'd0);
        for (int t = 0; t < 3; t++) begin
            @(negedge Clock);
            check("abort_quiet", 32'({Done, ByteValid, Busy}), 32'd0);
        end
        run_vec(vecs[0], "restart");

        // Reset and Start together: reset wins, stays IDLE.
        @(negedge Clock);
        Reset = 1'b1;
        Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        check("rst_start_busy", 32'(Busy), 32'd0);
        @(negedge Clock);
        check("rst_start_busy2", 32'(Busy), 32'd0);
        check("rst_start_bvalid", 32'(ByteValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
